reg32: RTL and testbench
========================

Name: reg32

Overview:
- Parameterisable-width (default 32-bit) data register with load enable and synchronous reset.
- Generic pipeline/holding register for accelerator datapaths: captures operands, partial sums and configuration words between stages.
- Output is purely registered; no combinational path from any input to the output.

Parameters:
- WIDTH, 32, data width in bits of in and out; legal range 1..1024.
- RESET_VALUE, 0 (WIDTH bits), value loaded into out on reset; truncated/zero-extended to WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- in  input  WIDTH  data to load.
- en  input  1  load enable, active-high.
- out  output  WIDTH  registered data.
- Positional declaration order is fixed: in, clk, en, rst, out. Existing positional instances depend on this order.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). No asynchronous reset path exists.
- At each rising edge of clk:
  - rst=1: out <= RESET_VALUE, regardless of en and in.
  - rst=0, en=1: out <= in. The value of in sampled at that edge appears on out after the edge (1-cycle latency).
  - rst=0, en=0: out holds its previous value indefinitely.
- Priority: rst over en.
- Reset mid-operation: the next edge with rst=1 discards the held value. Clearing rst resumes normal load/hold on the following edge, with no recovery cycles.
- Changes on in between edges have no effect on out (no transparency, no glitch propagation).
- en and rst changes take effect only at the next rising edge.
- Power-up before the first reset edge: out is undefined in silicon. Simulation models initialise to RESET_VALUE only if the team's simulation init macro is used; otherwise X is acceptable.
- All WIDTH bits load and hold as one unit; no partial writes.

Optional Feature:
- Macro: REG32_PARITY_EN.
- Defined:
  - Adds a sixth port, par (output, 1 bit), declared after out.
  - par is a registered even-parity bit equal to XOR of the bits written to out. It updates on the same edges, with the same rst/en priority, as out.
  - On reset, par = XOR of RESET_VALUE (0 for default).
  - Hold behaviour is identical to out.
- Not defined: par does not exist; port list is exactly the five ports above. Existing 5-port positional instances compile unchanged either way.

Test Plan:
- Load: rst=0, en=1, in=32'hDEADBEEF at edge N -> out=32'hDEADBEEF after edge N; in changes to 32'h12345678 mid-cycle -> out unchanged until edge N+1, then 32'h12345678.
- Hold: load 32'hA5A5A5A5, then en=0 and drive random in for 50 edges -> out stays 32'hA5A5A5A5 throughout.
- Reset priority: out=32'hFFFFFFFF, assert rst=1 with en=1, in=32'h0000FFFF -> out=32'h00000000 after the next edge. Out stays 0 while rst=1, even with en=1.
- Reset while disabled: en=0, out=32'h0BADF00D, rst=1 for one edge -> out=0. rst=0, en=0 -> out remains 0. en=1, in=32'h00000007 -> out=7 after the next edge.
- Synchronous reset check: pulse rst high between two rising edges, not spanning one -> out unchanged. Non-default RESET_VALUE=32'hC0FFEE00 with rst spanning an edge -> out=32'hC0FFEE00.
- REG32_PARITY_EN: load 32'h00000007 -> par=1. Load 32'h00000003 -> par=0. rst -> par=0. en=0 with changing in -> par holds.

Source files
------------

// File: rtl/reg32.sv
// Parameterisable holding register with load enable and synchronous reset.
// Optional registered even-parity output enabled by defining REG32_PARITY_EN.
module reg32 #(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic [WIDTH-1:0] in,
    input  logic             clk,
    input  logic             en,
    input  logic             rst,
    output logic [WIDTH-1:0] out
`ifdef REG32_PARITY_EN
    ,
    output logic             par
`endif
);

    localparam int unsigned MIN_WIDTH = 1;
    localparam int unsigned MAX_WIDTH = 1024;

    // Reject illegal widths at elaboration rather than building a broken register.
    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("reg32: WIDTH %0d outside legal range 1..1024", WIDTH);
    end

    // Reset dominates enable; the whole word moves as one unit.
    always_ff @(posedge clk) begin
        if (rst) begin
            out <= RESET_VALUE;
        end else if (en) begin
            out <= in;
        end
    end

`ifdef REG32_PARITY_EN
    localparam logic RESET_PAR = ^RESET_VALUE;

    // Parity tracks exactly the value written to out, on the same edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            par <= RESET_PAR;
        end else if (en) begin
            par <= ^in;
        end
    end
`endif

endmodule

// File: tb/tb_reg32.sv
// Directed self-checking bench for reg32: load, hold, reset priority, sync reset, width 1.
// Parity checks are compiled in when REG32_PARITY_EN is defined.
module tb_reg32;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] in;
    logic [31:0] out;
    logic [31:0] out_rv;
    logic        out_w1;
    int          passed;
    int          total;
`ifdef REG32_PARITY_EN
    logic        par;
    logic        par_rv;
    logic        par_w1;
`endif

    reg32 dut (
        .in  (in),
        .clk (clk),
        .en  (en),
        .rst (rst),
        .out (out)
`ifdef REG32_PARITY_EN
        ,
        .par (par)
`endif
    );

    reg32 #(.WIDTH(32), .RESET_VALUE(32'hC0FFEE00)) dut_rv (
        .in  (in),
        .clk (clk),
        .en  (en),
        .rst (rst),
        .out (out_rv)
`ifdef REG32_PARITY_EN
        ,
        .par (par_rv)
`endif
    );

    reg32 #(.WIDTH(1), .RESET_VALUE(1'b1)) dut_w1 (
        .in  (in[0]),
        .clk (clk),
        .en  (en),
        .rst (rst),
        .out (out_w1)
`ifdef REG32_PARITY_EN
        ,
        .par (par_w1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst = 1'b1;
        en  = 1'b0;
        in  = 32'h0;

        // Reset state
        tick();
        check("reset_default", out, 32'h0);
        check("reset_rv", out_rv, 32'hC0FFEE00);
        check("reset_w1", 32'(out_w1), 32'h1);

        // Load with one-cycle latency; mid-cycle input change is invisible
        rst = 1'b0;
        en  = 1'b1;
        in  = 32'hDEADBEEF;
        tick();
        check("load_deadbeef", out, 32'hDEADBEEF);
        check("load_w1", 32'(out_w1), 32'h1);
        #3 in = 32'h12345678;
        #1 check("midcycle_no_effect", out, 32'hDEADBEEF);
        tick();
        check("load_12345678", out, 32'h12345678);
        check("load_w1_zero", 32'(out_w1), 32'h0);

        // Hold across 50 edges of random input
        in = 32'hA5A5A5A5;
        tick();
        check("load_a5", out, 32'hA5A5A5A5);
        en = 1'b0;
        for (int i = 0; i < 50; i++) begin
            in = $urandom;
            tick();
            check("hold_a5", out, 32'hA5A5A5A5);
        end
        check("hold_w1", 32'(out_w1), 32'h1);

        // Reset has priority over enable
        en = 1'b1;
        in = 32'hFFFFFFFF;
        tick();
        check("load_ffff", out, 32'hFFFFFFFF);
        rst = 1'b1;
        in  = 32'h0000FFFF;
        tick();
        check("rst_over_en", out, 32'h0);
        check("rst_over_en_rv", out_rv, 32'hC0FFEE00);
        check("rst_over_en_w1", 32'(out_w1), 32'h1);
        tick();
        check("rst_held", out, 32'h0);

        // Reset while disabled, then resume with no recovery cycles
        rst = 1'b0;
        in  = 32'h0BADF00D;
        tick();
        check("load_0badf00d", out, 32'h0BADF00D);
        en  = 1'b0;
        rst = 1'b1;
        tick();
        check("rst_while_dis", out, 32'h0);
        rst = 1'b0;
        in  = 32'hFFFFFFFF;
        tick();
        check("post_rst_hold", out, 32'h0);
        en = 1'b1;
        in = 32'h00000007;
        tick();
        check("resume_load", out, 32'h7);

        // A reset pulse between edges must not act
        en = 1'b0;
        #2 rst = 1'b1;
        #3 rst = 1'b0;
        tick();
        check("sync_rst_pulse", out, 32'h7);
        check("sync_rst_pulse_rv", out_rv, 32'h7);

`ifdef REG32_PARITY_EN
        en = 1'b1;
        in = 32'h00000007;
        tick();
        check("par_load7", 32'(par), 32'h1);
        in = 32'h00000003;
        tick();
        check("par_load3", 32'(par), 32'h0);
        in = 32'h00000001;
        tick();
        check("par_load1", 32'(par), 32'h1);
        rst = 1'b1;
        tick();
        check("par_reset", 32'(par), 32'h0);
        check("par_reset_rv", 32'(par_rv), 32'h0);
        check("par_reset_w1", 32'(par_w1), 32'h1);
        rst = 1'b0;
        in  = 32'h00000007;
        tick();
        check("par_reload7", 32'(par), 32'h1);
        en = 1'b0;
        in = 32'h00000003;
        tick();
        check("par_hold_a", 32'(par), 32'h1);
        in = 32'h00000000;
        tick();
        check("par_hold_b", 32'(par), 32'h1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
